// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency single-word data memory responder
//
// Purpose: target end of the data-cache / store-buffer memory interface.
//   Accepts one word read or write per request. The responder holds
//   requested_data_to_mem high for LATENCY cycles. It then commits the
//   write, or returns the read data together with a one-cycle read_valid
//   pulse. Requests that arrive while busy are ignored and are not queued.
//
// Optional macro: DMEM_ERR_EN
//   When defined, the err port exists and out-of-range word indices are
//   rejected: writes are dropped and reads return 0. err pulses when busy
//   falls for such a request. err also pulses at acceptance when
//   mem_read and mem_write are both high.
//   When undefined, the word index wraps modulo DEPTH_WORDS.
//
// Ports:
//   clk                    rising-edge clock
//   reset                  asynchronous active-high reset
//   mem_read, mem_write    request strobes, sampled only in IDLE (write wins)
//   address                byte address, bits [1:0] ignored
//   writedata              write data, captured with the request
//   requested_data_to_mem  busy, high while a request is in service
//   readdata               last read result, held until the next read completes
//   read_valid             one-cycle pulse when readdata updates
//   err                    one-cycle error pulse (DMEM_ERR_EN only)

module data_mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] writedata,
  output logic        requested_data_to_mem,
  output logic [31:0] readdata,
  output logic        read_valid
`ifdef DMEM_ERR_EN
  ,
  output logic        err
`endif
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_write_q, op_write_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               oor_q, oor_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               busy_q, busy_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d;
  logic               mem_we;
  logic [31:0]        mem_q [DEPTH_WORDS];

  // Out-of-range detection only matters when the error feature is built in;
  // without it the upper address bits are discarded and the index wraps.
  logic addr_oor;
`ifdef DMEM_ERR_EN
  logic err_q, err_d;
  assign addr_oor = |address[31:IDX_W+2];
  assign err      = err_q;
  logic unused_addr;
  assign unused_addr = ^address[1:0];
`else
  assign addr_oor = 1'b0;
  logic unused_addr;
  assign unused_addr = ^{address[1:0], address[31:IDX_W+2]};
`endif

  assign requested_data_to_mem = busy_q;
  assign readdata              = rdata_q;
  assign read_valid            = rvalid_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_write_d = op_write_q;
    idx_d      = idx_q;
    oor_d      = oor_q;
    wdata_d    = wdata_q;
    busy_d     = busy_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;
    mem_we     = 1'b0;
`ifdef DMEM_ERR_EN
    err_d      = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (mem_read || mem_write) begin
          op_write_d = mem_write;
          idx_d      = address[IDX_W+1:2];
          oor_d      = addr_oor;
          wdata_d    = writedata;
          busy_d     = 1'b1;
          cnt_d      = CNT_W'(LATENCY - 1);
          state_d    = ST_BUSY;
`ifdef DMEM_ERR_EN
          err_d      = mem_read && mem_write;
`endif
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (op_write_q) begin
            mem_we = !oor_q;
          end else begin
            rdata_d  = oor_q ? 32'h0 : mem_q[idx_q];
            rvalid_d = 1'b1;
          end
`ifdef DMEM_ERR_EN
          err_d   = oor_q;
`endif
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_write_q <= 1'b0;
      idx_q      <= '0;
      oor_q      <= 1'b0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
`ifdef DMEM_ERR_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_write_q <= op_write_d;
      idx_q      <= idx_d;
      oor_q      <= oor_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
`ifdef DMEM_ERR_EN
      err_q      <= err_d;
`endif
    end
  end

  // Storage is cleared by reset so that an aborted write leaves no trace.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized self-checking bench for data_mem_responder

module tb_data_mem_responder;

  localparam int DEPTH = 64;
  localparam int LAT   = 5;

  logic        clk;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] address;
  logic [31:0] writedata;
  logic        busy;
  logic [31:0] readdata;
  logic        rvalid;
`ifdef DMEM_ERR_EN
  logic        err;
`endif

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .mem_read              (mem_read),
    .mem_write             (mem_write),
    .address               (address),
    .writedata             (writedata),
    .requested_data_to_mem (busy),
    .readdata              (readdata),
    .read_valid            (rvalid)
`ifdef DMEM_ERR_EN
    ,
    .err                   (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] mem_m [DEPTH];
  logic [31:0] last_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called at a negedge with the DUT idle. Presents one request, then walks
  // through the service window checking busy, the held readdata and the
  // quiet pulses. At the end it checks the completion against the model.
  // poke >= 0 drives a stray request during that busy cycle.
  task automatic do_req(input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [31:0] data, input int poke);
    bit oor;
    int idx;
    oor = 1'b0;
`ifdef DMEM_ERR_EN
    oor = (addr[31:2] >= DEPTH);
`endif
    idx = int'((addr >> 2) % DEPTH);
    mem_write = wr;
    mem_read  = rd;
    address   = addr;
    writedata = data;
    @(negedge clk);
    mem_write = 1'b0;
    mem_read  = 1'b0;
    address   = $urandom;
    writedata = $urandom;
    for (int i = 0; i < LAT; i++) begin
      check("busy_high", 32'(busy), 32'd1);
      check("rvalid_quiet", 32'(rvalid), 32'd0);
      check("rdata_hold", readdata, last_rd);
`ifdef DMEM_ERR_EN
      check("err_accept", 32'(err), 32'((i == 0) && wr && rd));
`endif
      if (i == poke) begin
        mem_read  = 1'b1;
        mem_write = 1'($urandom);
        address   = 32'h8;
        writedata = 32'hDEAD_0000;
      end
      @(negedge clk);
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
    if (wr) begin
      if (!oor) mem_m[idx] = data;
    end else begin
      last_rd = oor ? 32'h0 : mem_m[idx];
    end
    check("busy_fall", 32'(busy), 32'd0);
    check("rvalid_pulse", 32'(rvalid), 32'(!wr));
    check("rdata", readdata, last_rd);
`ifdef DMEM_ERR_EN
    check("err_done", 32'(err), 32'(oor));
`endif
  endtask

  initial begin
    bit          w, r;
    logic [31:0] a;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
    last_rd   = 32'h0;
    reset     = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    address   = 32'h0;
    writedata = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdata", readdata, 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    do_req(1, 0, 32'h4, 32'h1, -1);
    do_req(0, 1, 32'h4, 32'h0, -1);

    for (int k = 0; k <= 10; k++) do_req(1, 0, 32'(k * 4), 32'(k + 1), -1);
    do_req(0, 1, 32'h14, 32'h0, -1);
    check("plan_rd_0x14", readdata, 32'h6);

    do_req(1, 0, 32'h8, 32'hAB, 2);
    do_req(0, 1, 32'h8, 32'h0, -1);
    check("plan_rd_0x8", readdata, 32'hAB);

    do_req(1, 1, 32'hC, 32'h55, -1);
    do_req(0, 1, 32'hC, 32'h0, LAT - 1);
    check("plan_conflict", readdata, 32'h55);

    do_req(1, 0, 32'h100, 32'h7, -1);
    do_req(0, 1, 32'h100, 32'h0, -1);
    do_req(0, 1, 32'h0, 32'h0, -1);

    // Reset lands asynchronously in the third busy cycle of a write.
    mem_write = 1'b1;
    address   = 32'h10;
    writedata = 32'h9;
    @(negedge clk);
    mem_write = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rvalid", 32'(rvalid), 32'd0);
    check("abort_rdata", readdata, 32'h0);
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
    last_rd = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    do_req(0, 1, 32'h10, 32'h0, -1);
    check("abort_no_commit", readdata, 32'h0);

    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 9))
        0:       begin w = 1; r = 1; end
        1, 2, 3: begin w = 0; r = 1; end
        default: begin w = 1; r = 0; end
      endcase
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = (32'($urandom_range(0, 79)) << 2) | 32'($urandom_range(0, 3));
      do_req(w, r, a, $urandom,
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, LAT - 1)) : -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Behavioural data-memory responder; the target end of the data-cache/store-buffer memory request interface.
- Accepts a single word read or write request (mem_read/mem_write, address, writedata).
- Holds requested_data_to_mem high for a fixed service latency, then commits the write or returns read data with a one-cycle valid pulse.
- Used as the memory side in cache and store-buffer testbenches and in the processor top level.

Parameters:
DEPTH_WORDS, 64, number of 32-bit words stored; power of two, at least 2.
LATENCY, 5, cycles requested_data_to_mem stays high per accepted request; at least 1.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
mem_read  input  1  read request, sampled only in IDLE
mem_write  input  1  write request, sampled only in IDLE; has priority over mem_read
address  input  32  byte address; bits [1:0] ignored (word access)
writedata  input  32  write data, captured with the request
requested_data_to_mem  output  1  busy; high while a request is in service
readdata  output  32  read data; holds its value until the next read completes
read_valid  output  1  one-cycle pulse when readdata is updated by a completed read
err  output  1  one-cycle error pulse; present only with DMEM_ERR_EN

Behaviour:
- Clocking and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values:
  - state=IDLE, requested_data_to_mem=0, readdata=0, read_valid=0, err=0, counter=0.
  - All DEPTH_WORDS memory words cleared to 0.
- Reset mid-operation: the in-flight request is aborted with no write commit and no read_valid.
- State machine, IDLE to BUSY (rising edge in IDLE with mem_read or mem_write high):
  - Capture op, word index = address[31:2], and writedata.
  - Set requested_data_to_mem=1 and cnt=LATENCY-1; go to BUSY.
- BUSY:
  - If cnt!=0: decrement cnt.
  - If cnt==0:
    - Write: store the captured data into mem.
    - Read: load readdata from mem and pulse read_valid=1.
    - Set requested_data_to_mem=0; go to IDLE.
- Timing:
  - Busy is high for exactly LATENCY cycles, starting the cycle after acceptance.
  - Read data is visible in the same cycle busy falls.
  - A new request can be accepted on the first rising edge in IDLE; there is no dead cycle inside the responder.
- Requests while BUSY: ignored entirely, not queued. Initiators must hold or reissue the request.
- Simultaneous mem_read and mem_write: treated as a write. With DMEM_ERR_EN, err pulses at acceptance.
- Read-after-write to the same word: returns the new data, because the write commits before the next acceptance.
- read_valid and err: low in every cycle other than their defined pulses.

Optional Feature:
Macro DMEM_ERR_EN.
- Defined:
  - err port exists.
  - Word index >= DEPTH_WORDS is out of range: writes are dropped; reads return readdata=0 with read_valid pulsed.
  - err pulses in the cycle busy falls for any out-of-range request.
  - err also pulses at acceptance for simultaneous read and write.
- Undefined:
  - No err port.
  - Word index wraps modulo DEPTH_WORDS (index = address[log2(DEPTH_WORDS)+1:2]).
  - The read+write conflict resolves silently as a write.

Test Plan:
- Reset, then write address 0x4 with data 0x1 -> busy high 5 cycles, read_valid stays 0. Next read of 0x4 -> after 5 busy cycles readdata=0x1, read_valid pulses for exactly 1 cycle.
- Back-to-back writes 0x0..0x28 with data 1..11, each issued when busy=0, then read 0x14 -> readdata=0x6. Each request is accepted on the first idle edge.
- Issue a read of 0x8 while busy from a prior write to 0x8 with data 0xAB -> the mid-busy request is ignored. A read reissued after busy falls returns 0xAB.
- mem_read=1 and mem_write=1 to 0xC with data 0x55 -> treated as a write; a subsequent read returns 0x55. With DMEM_ERR_EN, err pulses at acceptance.
- Address 0x100 (word 64) with DEPTH_WORDS=64:
  - With DMEM_ERR_EN: a write is dropped and err pulses; a read returns 0 and err pulses.
  - Without it: a write to 0x100 data 0x7 aliases word 0, so a read of 0x0 returns 0x7.
- Assert reset asynchronously on the 3rd busy cycle of a write to 0x10 data 0x9 -> busy drops immediately. A read of 0x10 after reset returns 0 and no read_valid was emitted for the aborted request.
